dma_cfg_regs: RTL and testbench
===============================

Name: dma_cfg_regs

Overview:
Register file and channel controller directly downstream of the AHB-Lite slave's cfg interface (c_ad/c_we/c_cs/c_wd/c_rd). It holds the DMA channel programming: source, destination, length and control. It issues a single-cycle start pulse to the transfer engine and tracks busy/done/error status. It raises an interrupt and drives flow_ready back to the slave.

Parameters:
AHB_SLAVE_VOL, 64, byte size of the register window (16 words)
AHB_ADDR_SIZE, 32, width of c_ad_i and of the address registers
AHB_DATA_SIZE, 32, width of c_wd_i/c_rd_o
LEN_W, 16, width of the transfer length register (bytes)
ID_VALUE, 32'h0D4A_0001, constant returned by the ID register

Ports:
hclk  in  1  clock
hreset  in  1  synchronous active-high reset
c_ad_i  in  AHB_ADDR_SIZE  byte address from slave; bits [LAW-1:2] decoded, [1:0] ignored
c_we_i  in  1  1 = write, 0 = read
c_cs_i  in  1  access strobe, one cycle per access (data phase)
c_wd_i  in  AHB_DATA_SIZE  write data, valid while c_cs_i=1
c_rd_o  out  AHB_DATA_SIZE  read data, combinational from c_ad_i
flow_ready_o  out  1  1 when channel idle (to slave flow_ready_i)
src_addr_o  out  AHB_ADDR_SIZE  source address to engine
dst_addr_o  out  AHB_ADDR_SIZE  destination address to engine
len_o  out  LEN_W  byte count to engine
start_o  out  1  one-cycle start pulse to engine
eng_done_i  in  1  engine completion pulse
eng_err_i  in  1  engine bus-error pulse (also terminates transfer)
irq_o  out  1  level interrupt

Behaviour:
- Register map (word offset): 0x00 CTRL, 0x04 STATUS, 0x08 SRC, 0x0C DST, 0x10 LEN, 0x14 ID. 0x18..end are unmapped: read 0, writes ignored.
- CTRL: bit0 START (write-1 action, reads 0); bit1 IRQ_EN (RW). Other bits read 0.
- STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C); bit3 OVR (W1C). Writes to BUSY are ignored.
- SRC/DST are RW, full width. LEN is RW on [LEN_W-1:0]; upper bits read 0. ID is RO.
- Write takes effect at the hclk edge where c_cs_i & c_we_i. Read data is valid in the same cycle c_cs_i is high, with no wait states.
- FSM states: IDLE, RUN.
- IDLE, write CTRL.START=1, LEN!=0: next cycle start_o=1 for exactly one cycle. BUSY=1 and state goes to RUN on that same edge. src/dst/len outputs reflect the registers, which are frozen during RUN.
- IDLE, START with LEN==0: no start_o; DONE sets on the next edge; state stays IDLE.
- RUN, eng_done_i: next cycle BUSY=0, DONE=1, state goes to IDLE.
- RUN, eng_err_i: next cycle BUSY=0, ERR=1, state goes to IDLE. If eng_err_i and eng_done_i arrive together, ERR=1 and DONE stays 0.
- RUN, write to SRC/DST/LEN/CTRL.START: the write is ignored and OVR=1. IRQ_EN writes are still honoured during RUN.
- eng_done_i/eng_err_i in IDLE are ignored.
- W1C on the same edge as a hardware set of the same bit: set wins.
- START written together with IRQ_EN in one CTRL write: both take effect.
- flow_ready_o = ~BUSY (combinational from state).
- irq_o = IRQ_EN & (DONE | ERR), registered from register state, no extra latency.
- Reset (any time, including mid-RUN): state IDLE, all registers 0, all outputs 0 except flow_ready_o=1. start_o=0 regardless of a pending START. c_rd_o follows the register contents, so ID reads ID_VALUE.
- Local parameter LAW = $clog2(AHB_SLAVE_VOL).

Decomposition:
- Shared package gets:
  - register offset localparams (CTRL_OFF..ID_OFF);
  - STATUS/CTRL bit-index constants;
  - the fsm typedef dma_ch_state_t {CH_IDLE, CH_RUN}.
- One natural sub-module: dma_cfg_decode, a combinational address decode producing per-register select one-hots plus the read mux. The FSM and registers stay in the top module.

Test Plan:
- After reset, read 0x04 -> 0; read 0x14 -> 32'h0D4A_0001; read 0x18 -> 0; flow_ready_o=1.
- Write SRC=0x1000, DST=0x2000, LEN=0x40, CTRL=0x3 -> start_o high exactly one cycle after the CTRL write, src/dst/len_o = 0x1000/0x2000/0x40, STATUS=0x1, flow_ready_o=0.
- In RUN, write SRC=0xDEAD, then pulse eng_done_i -> SRC still 0x1000, STATUS=0xA, irq_o=1. Write STATUS=0xA -> STATUS=0, irq_o=0.
- START with LEN=0 -> no start_o, STATUS=0x2 next cycle. With IRQ_EN=0, irq_o stays 0.
- In RUN, assert eng_done_i and eng_err_i in the same cycle -> STATUS=0x4. Then W1C ERR on the same edge as a new eng_err_i from a fresh run -> ERR remains 1.
- Assert hreset mid-RUN -> next cycle start_o=0, STATUS=0, SRC/DST/LEN=0, flow_ready_o=1. A later eng_done_i is ignored.

Source files
------------

// File: rtl/dma_cfg_regs_pkg.sv
// rtl/dma_cfg_regs_pkg.sv - register map, bit indices and channel state for the DMA config block
package dma_cfg_regs_pkg;

  // Byte offsets of the mapped registers inside the window
  localparam logic [7:0] CTRL_OFF   = 8'h00;
  localparam logic [7:0] STATUS_OFF = 8'h04;
  localparam logic [7:0] SRC_OFF    = 8'h08;
  localparam logic [7:0] DST_OFF    = 8'h0C;
  localparam logic [7:0] LEN_OFF    = 8'h10;
  localparam logic [7:0] ID_OFF     = 8'h14;

  // Positions in the one-hot register select vector
  localparam int SEL_CTRL   = 0;
  localparam int SEL_STATUS = 1;
  localparam int SEL_SRC    = 2;
  localparam int SEL_DST    = 3;
  localparam int SEL_LEN    = 4;
  localparam int SEL_ID     = 5;
  localparam int NUM_REGS   = 6;

  // CTRL bits
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS bits
  localparam int ST_BUSY_BIT = 0;
  localparam int ST_DONE_BIT = 1;
  localparam int ST_ERR_BIT  = 2;
  localparam int ST_OVR_BIT  = 3;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } dma_ch_state_t;

endpackage

// File: rtl/dma_cfg_regs_if.sv
// rtl/dma_cfg_regs_if.sv - cfg access bus between the AHB-Lite slave and the register file
interface dma_cfg_regs_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] c_ad_i;
  logic              c_we_i;
  logic              c_cs_i;
  logic [DATA_W-1:0] c_wd_i;
  logic [DATA_W-1:0] c_rd_o;

  modport master (
    output c_ad_i, c_we_i, c_cs_i, c_wd_i,
    input  c_rd_o
  );

  modport slave (
    input  c_ad_i, c_we_i, c_cs_i, c_wd_i,
    output c_rd_o
  );
endinterface

// File: rtl/dma_cfg_decode.sv
// rtl/dma_cfg_decode.sv - address decode to one-hot register selects plus read data mux
module dma_cfg_decode
  import dma_cfg_regs_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAW = 6
) (
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       ctrl_word,
  input  logic [DW-1:0]       status_word,
  input  logic [DW-1:0]       src_word,
  input  logic [DW-1:0]       dst_word,
  input  logic [DW-1:0]       len_word,
  input  logic [DW-1:0]       id_word,
  output logic [NUM_REGS-1:0] sel,
  output logic [DW-1:0]       rd_data
);

  logic [LAW-1:0] word_addr;
  logic           unused_addr_bits;

  // Byte lane bits and bits above the window do not take part in decode
  assign word_addr        = {addr[LAW-1:2], 2'b00};
  assign unused_addr_bits = ^{addr[AW-1:LAW], addr[1:0]};

  // One-hot select; unmapped offsets leave every select low
  always_comb begin
    sel             = '0;
    sel[SEL_CTRL]   = (word_addr == LAW'(CTRL_OFF));
    sel[SEL_STATUS] = (word_addr == LAW'(STATUS_OFF));
    sel[SEL_SRC]    = (word_addr == LAW'(SRC_OFF));
    sel[SEL_DST]    = (word_addr == LAW'(DST_OFF));
    sel[SEL_LEN]    = (word_addr == LAW'(LEN_OFF));
    sel[SEL_ID]     = (word_addr == LAW'(ID_OFF));
  end

  // AND-OR read mux so unmapped addresses naturally read zero
  always_comb begin
    rd_data = ({DW{sel[SEL_CTRL]}}   & ctrl_word)
            | ({DW{sel[SEL_STATUS]}} & status_word)
            | ({DW{sel[SEL_SRC]}}    & src_word)
            | ({DW{sel[SEL_DST]}}    & dst_word)
            | ({DW{sel[SEL_LEN]}}    & len_word)
            | ({DW{sel[SEL_ID]}}     & id_word);
  end

endmodule

// File: rtl/dma_cfg_regs.sv
// rtl/dma_cfg_regs.sv - DMA channel register file and IDLE/RUN channel controller
module dma_cfg_regs
  import dma_cfg_regs_pkg::*;
#(
  parameter int                       AHB_SLAVE_VOL = 64,
  parameter int                       AHB_ADDR_SIZE = 32,
  parameter int                       AHB_DATA_SIZE = 32,
  parameter int                       LEN_W         = 16,
  parameter logic [AHB_DATA_SIZE-1:0] ID_VALUE      = 32'h0D4A_0001
) (
  input  logic                     hclk,
  input  logic                     hreset,
  dma_cfg_regs_if.slave            cfg,
  output logic                     flow_ready_o,
  output logic [AHB_ADDR_SIZE-1:0] src_addr_o,
  output logic [AHB_ADDR_SIZE-1:0] dst_addr_o,
  output logic [LEN_W-1:0]         len_o,
  output logic                     start_o,
  input  logic                     eng_done_i,
  input  logic                     eng_err_i,
  output logic                     irq_o
);

  localparam int LAW = $clog2(AHB_SLAVE_VOL);

  dma_ch_state_t              state;
  logic                       irq_en;
  logic                       done;
  logic                       err;
  logic                       ovr;
  logic                       busy;
  logic [NUM_REGS-1:0]        sel;
  logic [AHB_DATA_SIZE-1:0]   ctrl_word;
  logic [AHB_DATA_SIZE-1:0]   status_word;
  logic                       wr;
  logic                       start_req;
  logic                       prog_wr;

  assign busy         = (state == CH_RUN);
  assign flow_ready_o = ~busy;
  assign irq_o        = irq_en & (done | err);

  assign wr        = cfg.c_cs_i & cfg.c_we_i;
  assign start_req = wr & sel[SEL_CTRL] & cfg.c_wd_i[CTRL_START_BIT];
  assign prog_wr   = wr & (sel[SEL_SRC] | sel[SEL_DST] | sel[SEL_LEN]);

  // Readback images of CTRL (START always reads 0) and STATUS
  always_comb begin
    ctrl_word                   = '0;
    ctrl_word[CTRL_IRQ_EN_BIT]  = irq_en;
    status_word                 = '0;
    status_word[ST_BUSY_BIT]    = busy;
    status_word[ST_DONE_BIT]    = done;
    status_word[ST_ERR_BIT]     = err;
    status_word[ST_OVR_BIT]     = ovr;
  end

  dma_cfg_decode #(
    .AW  (AHB_ADDR_SIZE),
    .DW  (AHB_DATA_SIZE),
    .LAW (LAW)
  ) u_decode (
    .addr        (cfg.c_ad_i),
    .ctrl_word   (ctrl_word),
    .status_word (status_word),
    .src_word    (AHB_DATA_SIZE'(src_addr_o)),
    .dst_word    (AHB_DATA_SIZE'(dst_addr_o)),
    .len_word    (AHB_DATA_SIZE'(len_o)),
    .id_word     (ID_VALUE),
    .sel         (sel),
    .rd_data     (cfg.c_rd_o)
  );

  // Channel FSM and register updates; W1C is applied first so a same-edge hardware set wins
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= CH_IDLE;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ovr        <= 1'b0;
      src_addr_o <= '0;
      dst_addr_o <= '0;
      len_o      <= '0;
      start_o    <= 1'b0;
    end else begin
      start_o <= 1'b0;

      if (wr && sel[SEL_CTRL]) begin
        irq_en <= cfg.c_wd_i[CTRL_IRQ_EN_BIT];
      end

      if (wr && sel[SEL_STATUS]) begin
        if (cfg.c_wd_i[ST_DONE_BIT]) done <= 1'b0;
        if (cfg.c_wd_i[ST_ERR_BIT])  err  <= 1'b0;
        if (cfg.c_wd_i[ST_OVR_BIT])  ovr  <= 1'b0;
      end

      case (state)
        CH_IDLE: begin
          if (wr && sel[SEL_SRC]) src_addr_o <= AHB_ADDR_SIZE'(cfg.c_wd_i);
          if (wr && sel[SEL_DST]) dst_addr_o <= AHB_ADDR_SIZE'(cfg.c_wd_i);
          if (wr && sel[SEL_LEN]) len_o      <= cfg.c_wd_i[LEN_W-1:0];
          if (start_req) begin
            if (len_o != '0) begin
              start_o <= 1'b1;
              state   <= CH_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        CH_RUN: begin
          // Programming registers are frozen while the engine owns them
          if (prog_wr || start_req) begin
            ovr <= 1'b1;
          end
          if (eng_err_i) begin
            err   <= 1'b1;
            state <= CH_IDLE;
          end else if (eng_done_i) begin
            done  <= 1'b1;
            state <= CH_IDLE;
          end
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cfg_regs.sv
// tb/tb_dma_cfg_regs.sv - randomized self-checking bench for dma_cfg_regs against a behavioural model
module tb_dma_cfg_regs;

  localparam logic [31:0] ID_EXP = 32'h0D4A_0001;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        flow_ready_o;
  logic [31:0] src_addr_o;
  logic [31:0] dst_addr_o;
  logic [15:0] len_o;
  logic        start_o;
  logic        eng_done_i;
  logic        eng_err_i;
  logic        irq_o;

  dma_cfg_regs_if #(.ADDR_W(32), .DATA_W(32)) cfg ();

  dma_cfg_regs dut (
    .hclk         (hclk),
    .hreset       (hreset),
    .cfg          (cfg),
    .flow_ready_o (flow_ready_o),
    .src_addr_o   (src_addr_o),
    .dst_addr_o   (dst_addr_o),
    .len_o        (len_o),
    .start_o      (start_o),
    .eng_done_i   (eng_done_i),
    .eng_err_i    (eng_err_i),
    .irq_o        (irq_o)
  );

  always #5 hclk = ~hclk;

  int n_vec     = 0;
  int n_miscmp  = 0;

  // Behavioural model of the programmer-visible channel state
  logic [31:0] m_src, m_dst;
  logic [15:0] m_len;
  logic        m_irq_en, m_busy, m_done, m_err, m_ovr, m_start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] ad);
    case (ad[5:2])
      4'd0:    return {30'd0, m_irq_en, 1'b0};
      4'd1:    return {28'd0, m_ovr, m_err, m_done, m_busy};
      4'd2:    return m_src;
      4'd3:    return m_dst;
      4'd4:    return {16'd0, m_len};
      4'd5:    return ID_EXP;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic cs, input logic we,
                            input logic [31:0] ad, input logic [31:0] wd,
                            input logic ed, input logic ee);
    logic [3:0]  w;
    logic        wr;
    logic        was_busy;
    logic [15:0] len_now;
    w        = ad[5:2];
    wr       = cs && we;
    was_busy = m_busy;
    len_now  = m_len;
    m_start  = 1'b0;
    if (rst) begin
      m_src = 0; m_dst = 0; m_len = 0;
      m_irq_en = 0; m_busy = 0; m_done = 0; m_err = 0; m_ovr = 0;
      return;
    end
    if (wr && w == 4'd1) begin
      if (wd[1]) m_done = 1'b0;
      if (wd[2]) m_err  = 1'b0;
      if (wd[3]) m_ovr  = 1'b0;
    end
    if (wr && w == 4'd0) m_irq_en = wd[1];
    if (!was_busy) begin
      if (wr && w == 4'd2) m_src = wd;
      if (wr && w == 4'd3) m_dst = wd;
      if (wr && w == 4'd4) m_len = wd[15:0];
      if (wr && w == 4'd0 && wd[0]) begin
        if (len_now != 0) begin
          m_start = 1'b1;
          m_busy  = 1'b1;
        end else begin
          m_done = 1'b1;
        end
      end
    end else begin
      if (wr && (w == 4'd2 || w == 4'd3 || w == 4'd4 || (w == 4'd0 && wd[0]))) m_ovr = 1'b1;
      if (ee) begin
        m_err  = 1'b1;
        m_busy = 1'b0;
      end else if (ed) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end
  endtask

  // One clock of stimulus: read data checked mid-cycle, registered outputs just after the edge
  task automatic step(input logic rst, input logic cs, input logic we,
                      input logic [31:0] ad, input logic [31:0] wd,
                      input logic ed, input logic ee);
    hreset      = rst;
    cfg.c_cs_i  = cs;
    cfg.c_we_i  = we;
    cfg.c_ad_i  = ad;
    cfg.c_wd_i  = wd;
    eng_done_i  = ed;
    eng_err_i   = ee;
    @(negedge hclk);
    if (cs && !we) check("rdata", cfg.c_rd_o, model_read(ad));
    @(posedge hclk);
    model_edge(rst, cs, we, ad, wd, ed, ee);
    #1;
    check("start_o", 32'(start_o), 32'(m_start));
    check("flow_ready_o", 32'(flow_ready_o), 32'(!m_busy));
    check("src_addr_o", src_addr_o, m_src);
    check("dst_addr_o", dst_addr_o, m_dst);
    check("len_o", 32'(len_o), 32'(m_len));
    check("irq_o", 32'(irq_o), 32'(m_irq_en & (m_done | m_err)));
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] wd);
    step(1'b0, 1'b1, 1'b1, ad, wd, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] ad);
    step(1'b0, 1'b1, 1'b0, ad, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic ed, input logic ee);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, ed, ee);
  endtask

  initial begin
    logic [31:0] ad, wd;
    logic [2:0]  word;

    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rd(32'h04);
    rd(32'h14);
    check("id_const", cfg.c_rd_o, ID_EXP);
    rd(32'h18);

    // Normal run, overrun attempt, done and W1C clear
    wr(32'h08, 32'h1000);
    wr(32'h0C, 32'h2000);
    wr(32'h10, 32'h40);
    wr(32'h00, 32'h3);
    rd(32'h04);
    wr(32'h08, 32'hDEAD);
    idle(1'b1, 1'b0);
    rd(32'h04);
    rd(32'h08);
    wr(32'h04, 32'hA);
    rd(32'h04);

    // Zero-length start completes immediately with no pulse
    wr(32'h10, 32'h0);
    wr(32'h00, 32'h1);
    rd(32'h04);
    wr(32'h04, 32'h2);

    // Error beats done; W1C of ERR loses to a fresh error
    wr(32'h10, 32'h8);
    wr(32'h00, 32'h1);
    idle(1'b1, 1'b1);
    rd(32'h04);
    wr(32'h00, 32'h1);
    step(1'b0, 1'b1, 1'b1, 32'h04, 32'h4, 1'b0, 1'b1);
    rd(32'h04);

    // Reset mid-run, later engine pulse ignored
    wr(32'h04, 32'hF);
    wr(32'h00, 32'h3);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    rd(32'h04);
    rd(32'h08);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      word = 3'($urandom_range(0, 7));
      ad   = ($urandom() & 32'hFFFF_FFC3) | {27'd0, word, 2'b00};
      wd   = $urandom();
      if (word == 3'd4 && $urandom_range(0, 2) == 0) wd = 32'd0;
      if (word == 3'd0 && $urandom_range(0, 1) == 0) wd[0] = 1'b1;
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           ad, wd,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
